// File: rtl/bottom_hit_judge_pkg.sv
// Shared constants for the learn-mode scorer: lane count, lane-state
// encodings, vga_bottom field offsets and a popcount helper.
package bottom_hit_judge_pkg;

    localparam int NUM_LANES     = 7;
    localparam int POP_W         = $clog2(NUM_LANES + 1);
    localparam int BOT_SHIFT_LSB = 0;
    localparam int BOT_LANE_LSB  = 2;

    localparam logic [1:0] JS_IDLE   = 2'd0;
    localparam logic [1:0] JS_OPEN   = 2'd1;
    localparam logic [1:0] JS_JUDGED = 2'd2;
    localparam logic [1:0] JS_GRACE  = 2'd3;

    function automatic logic [POP_W-1:0] popcount(
        input logic [NUM_LANES-1:0] v
    );
        logic [POP_W-1:0] n;
        n = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            n = n + POP_W'(v[i]);
        end
        return n;
    endfunction

endpackage

// File: rtl/bottom_hit_judge_lane_judge.sv
// One note lane: IDLE/OPEN/JUDGED/GRACE judge with grace-window counter.
// wrong_o exists only when JUDGE_WRONG_PENALTY_EN is defined.
module lane_judge
    import bottom_hit_judge_pkg::*;
#(
    parameter int GRACE_CYC = 2500000
) (
    input  logic vga_clk,
    input  logic rst_n,
    input  logic enable,
    input  logic rearm,
    input  logic level,
    input  logic rise,
    input  logic fall,
    input  logic press,
    input  logic shift_ok,
`ifdef JUDGE_WRONG_PENALTY_EN
    output logic wrong_o,
`endif
    output logic hit_o,
    output logic miss_o
);

    localparam int CW = (GRACE_CYC > 1) ? $clog2(GRACE_CYC) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(GRACE_CYC - 1);

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          hit_q, hit_d;
    logic          miss_q, miss_d;
    logic          wrong_q, wrong_d;
    logic          valid;

    assign valid = press & shift_ok;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        wrong_d = 1'b0;
        if (!enable) begin
            state_d = JS_IDLE;
            cnt_d   = '0;
        end else if (rearm) begin
            // a note already on screen is never judged
            state_d = level ? JS_JUDGED : JS_IDLE;
            cnt_d   = '0;
        end else begin
            unique case (state_q)
                JS_IDLE: begin
                    wrong_d = press;
                    if (rise) state_d = JS_OPEN;
                end
                JS_OPEN: begin
                    if (valid) begin
                        hit_d   = 1'b1;
                        state_d = fall ? JS_IDLE : JS_JUDGED;
                    end else begin
                        wrong_d = press;
                        if (fall) begin
                            state_d = JS_GRACE;
                            cnt_d   = '0;
                        end
                    end
                end
                JS_GRACE: begin
                    if (valid) begin
                        hit_d   = 1'b1;
                        state_d = JS_IDLE;
                    end else begin
                        wrong_d = press;
                        if (rise) begin
                            miss_d  = 1'b1;
                            state_d = JS_OPEN;
                        end else if (cnt_q == CNT_LAST) begin
                            miss_d  = 1'b1;
                            state_d = JS_IDLE;
                        end else begin
                            cnt_d = cnt_q + 1'b1;
                        end
                    end
                end
                JS_JUDGED: begin
                    wrong_d = press;
                    if (fall) state_d = JS_IDLE;
                end
                default: state_d = JS_IDLE;
            endcase
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= JS_IDLE;
            cnt_q   <= '0;
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            wrong_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            wrong_q <= wrong_d;
        end
    end

    assign hit_o  = hit_q;
    assign miss_o = miss_q;
`ifdef JUDGE_WRONG_PENALTY_EN
    assign wrong_o = wrong_q;
`else
    logic unused_wrong;
    assign unused_wrong = wrong_q;
`endif

endmodule

// File: rtl/bottom_hit_judge.sv
// Learn-mode scorer on the vga_bottom bus: syncs keys, judges lanes, keeps score.
// Optional JUDGE_WRONG_PENALTY_EN adds wrong-press penalty and wrong_pulse.
module bottom_hit_judge
    import bottom_hit_judge_pkg::*;
#(
    parameter int GRACE_CYC  = 2500000,
    parameter int HIT_POINTS = 10,
    parameter int CNT_W      = 16
) (
    input  logic                 vga_clk,
    input  logic                 rst_n,
    input  logic [9:0]           vga_bottom,
    input  logic [NUM_LANES-1:0] key,
    input  logic [1:0]           user_shift,
    input  logic                 enable,
    input  logic                 clear,
    output logic                 hit_pulse,
    output logic                 miss_pulse,
`ifdef JUDGE_WRONG_PENALTY_EN
    output logic                 wrong_pulse,
`endif
    output logic [CNT_W-1:0]     score,
    output logic [7:0]           combo,
    output logic [7:0]           max_combo,
    output logic [CNT_W-1:0]     miss_count
);

    localparam int SW = CNT_W + 8;
    localparam logic [SW-1:0] CNT_MAX = SW'({CNT_W{1'b1}});

    logic [NUM_LANES-1:0] key_s1_q, key_s2_q, key_prev_q;
    logic [1:0]           sh_s1_q, sh_s2_q;
    logic [NUM_LANES-1:0] lanes_q, lanes_d, lanes_prev_q;
    logic [1:0]           bshift_q, bshift_d;
    logic                 en_prev_q;

    logic [NUM_LANES-1:0] key_edge, rise, fall, level;
    logic                 shift_ok, rearm;
    logic [NUM_LANES-1:0] hit_v, miss_v;
    logic [POP_W-1:0]     h, m;
    logic                 unused_bits;

    assign unused_bits = vga_bottom[9];
    assign lanes_d  = vga_bottom[BOT_LANE_LSB +: NUM_LANES];
    assign bshift_d = vga_bottom[BOT_SHIFT_LSB +: 2];
    assign key_edge = key_s2_q & ~key_prev_q;
    assign rise     = lanes_q & ~lanes_prev_q;
    assign fall     = ~lanes_q & lanes_prev_q;
    // raw bus OR'd in so a note held across reset is seen on the first cycle
    assign level    = lanes_q | lanes_d;
    assign shift_ok = (sh_s2_q == bshift_q);
    assign rearm    = clear | (enable & ~en_prev_q);

`ifdef JUDGE_WRONG_PENALTY_EN
    logic [NUM_LANES-1:0] wrong_v;
    logic [POP_W-1:0]     w;
`endif

    for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
        lane_judge #(
            .GRACE_CYC (GRACE_CYC)
        ) u_lane (
            .vga_clk  (vga_clk),
            .rst_n    (rst_n),
            .enable   (enable),
            .rearm    (rearm),
            .level    (level[i]),
            .rise     (rise[i]),
            .fall     (fall[i]),
            .press    (key_edge[i]),
            .shift_ok (shift_ok),
`ifdef JUDGE_WRONG_PENALTY_EN
            .wrong_o  (wrong_v[i]),
`endif
            .hit_o    (hit_v[i]),
            .miss_o   (miss_v[i])
        );
    end

    assign h = popcount(hit_v);
    assign m = popcount(miss_v);

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            key_s1_q     <= '0;
            key_s2_q     <= '0;
            key_prev_q   <= '0;
            sh_s1_q      <= '0;
            sh_s2_q      <= '0;
            lanes_q      <= '0;
            lanes_prev_q <= '0;
            bshift_q     <= '0;
            en_prev_q    <= 1'b0;
        end else begin
            key_s1_q     <= key;
            key_s2_q     <= key_s1_q;
            key_prev_q   <= key_s2_q;
            sh_s1_q      <= user_shift;
            sh_s2_q      <= sh_s1_q;
            lanes_q      <= lanes_d;
            lanes_prev_q <= lanes_q;
            bshift_q     <= bshift_d;
            en_prev_q    <= enable;
        end
    end

    logic [CNT_W-1:0] score_q, score_d, miss_q, miss_d;
    logic [7:0]       combo_q, combo_d, max_q, max_d;
    logic             hp_q, hp_d, mp_q, mp_d;
    logic [SW-1:0]    score_add, miss_add;
    logic [8:0]       combo_add;

`ifdef JUDGE_WRONG_PENALTY_EN
    logic          wp_q, wp_d;
    logic [SW-1:0] pen;
    assign w = popcount(wrong_v);
`endif

    always_comb begin
        score_add = SW'(score_q) + SW'(h) * SW'(HIT_POINTS);
        if (score_add > CNT_MAX) score_add = CNT_MAX;
        miss_add = SW'(miss_q) + SW'(m);
        if (miss_add > CNT_MAX) miss_add = CNT_MAX;
        combo_add = {1'b0, combo_q} + 9'(h);
        if (combo_add > 9'd255) combo_add = 9'd255;

        score_d = score_q;
        miss_d  = miss_q;
        combo_d = combo_q;
        max_d   = max_q;
        hp_d    = 1'b0;
        mp_d    = 1'b0;
`ifdef JUDGE_WRONG_PENALTY_EN
        wp_d = 1'b0;
        pen  = SW'(w) * SW'(HIT_POINTS / 2);
`endif
        if (clear) begin
            score_d = '0;
            miss_d  = '0;
            combo_d = '0;
            max_d   = '0;
        end else if (enable) begin
            score_d = score_add[CNT_W-1:0];
            miss_d  = miss_add[CNT_W-1:0];
            combo_d = (m != '0) ? 8'd0 : combo_add[7:0];
            hp_d    = (h != '0);
            mp_d    = (m != '0);
`ifdef JUDGE_WRONG_PENALTY_EN
            // penalty lands after the same-cycle hit bonus
            if (w != '0) begin
                score_d = (score_add > pen) ?
                          CNT_W'(score_add - pen) : '0;
                combo_d = 8'd0;
                wp_d    = 1'b1;
            end
`endif
            max_d = (combo_d > max_q) ? combo_d : max_q;
        end
    end

    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) begin
            score_q <= '0;
            miss_q  <= '0;
            combo_q <= '0;
            max_q   <= '0;
            hp_q    <= 1'b0;
            mp_q    <= 1'b0;
        end else begin
            score_q <= score_d;
            miss_q  <= miss_d;
            combo_q <= combo_d;
            max_q   <= max_d;
            hp_q    <= hp_d;
            mp_q    <= mp_d;
        end
    end

`ifdef JUDGE_WRONG_PENALTY_EN
    always_ff @(posedge vga_clk or negedge rst_n) begin
        if (!rst_n) wp_q <= 1'b0;
        else        wp_q <= wp_d;
    end
    assign wrong_pulse = wp_q;
`endif

    assign score      = score_q;
    assign miss_count = miss_q;
    assign combo      = combo_q;
    assign max_combo  = max_q;
    assign hit_pulse  = hp_q;
    assign miss_pulse = mp_q;

endmodule

// File: tb/tb_bottom_hit_judge.sv
// Directed bench for bottom_hit_judge (GRACE_CYC=8, HIT_POINTS=10).
// Honours JUDGE_WRONG_PENALTY_EN for the wrong-press expectations.
module tb_bottom_hit_judge;

    logic        vga_clk = 1'b0;
    logic        rst_n;
    logic [9:0]  vga_bottom;
    logic [6:0]  key;
    logic [1:0]  user_shift;
    logic        enable;
    logic        clear;
    logic        hit_pulse, miss_pulse;
    logic [15:0] score, miss_count;
    logic [7:0]  combo, max_combo;
`ifdef JUDGE_WRONG_PENALTY_EN
    logic        wrong_pulse;
`endif

    logic [6:0]  lanes;
    logic [1:0]  bshift;
    int          n_run  = 0;
    int          n_fail = 0;
    int          wrong_seen = 0;

    assign vga_bottom = {1'b0, lanes, bshift};

    always #5 vga_clk = ~vga_clk;

    bottom_hit_judge #(
        .GRACE_CYC  (8),
        .HIT_POINTS (10),
        .CNT_W      (16)
    ) dut (
        .vga_clk     (vga_clk),
        .rst_n       (rst_n),
        .vga_bottom  (vga_bottom),
        .key         (key),
        .user_shift  (user_shift),
        .enable      (enable),
        .clear       (clear),
        .hit_pulse   (hit_pulse),
        .miss_pulse  (miss_pulse),
`ifdef JUDGE_WRONG_PENALTY_EN
        .wrong_pulse (wrong_pulse),
`endif
        .score       (score),
        .combo       (combo),
        .max_combo   (max_combo),
        .miss_count  (miss_count)
    );

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge vga_clk);
            #1;
        end
    endtask

    task automatic watch(input int n, output int nh, output int nm);
        nh = 0;
        nm = 0;
        repeat (n) begin
            tick(1);
            if (hit_pulse)  nh++;
            if (miss_pulse) nm++;
`ifdef JUDGE_WRONG_PENALTY_EN
            if (wrong_pulse) wrong_seen++;
`endif
        end
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick(2);
        n_run++;
        if (score !== 16'd0) begin
            n_fail++; $display("FAIL reset_score: got %0d expected 0", score);
        end
        n_run++;
        if (combo !== 8'd0 || max_combo !== 8'd0) begin
            n_fail++; $display("FAIL reset_combo: got %0d/%0d expected 0/0", combo, max_combo);
        end
        n_run++;
        if (miss_count !== 16'd0) begin
            n_fail++; $display("FAIL reset_miss: got %0d expected 0", miss_count);
        end
        n_run++;
        if (hit_pulse !== 1'b0 || miss_pulse !== 1'b0) begin
            n_fail++; $display("FAIL reset_pulses: got %b%b expected 00", hit_pulse, miss_pulse);
        end
        rst_n = 1'b1;
        tick(3);
    endtask

    task automatic test_hit();
        lanes[0] = 1'b1;
        tick(4);
        key[0] = 1'b1;
        tick(3);
        n_run++;
        if (hit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL hit_early: got %b expected 0 at edge+3", hit_pulse);
        end
        tick(1);
        n_run++;
        if (hit_pulse !== 1'b1) begin
            n_fail++; $display("FAIL hit_latency: got %b expected 1 at edge+4", hit_pulse);
        end
        n_run++;
        if (score !== 16'd10 || combo !== 8'd1) begin
            n_fail++; $display("FAIL hit_score: got %0d/%0d expected 10/1", score, combo);
        end
        tick(1);
        n_run++;
        if (hit_pulse !== 1'b0) begin
            n_fail++; $display("FAIL hit_width: got %b expected 0", hit_pulse);
        end
        key = '0;
        lanes = '0;
        tick(4);
    endtask

    task automatic test_miss();
        int first;
        int cnt;
        first = 0;
        cnt = 0;
        lanes[3] = 1'b1;
        tick(20);
        lanes = '0;
        for (int c = 1; c <= 20; c++) begin
            tick(1);
            if (miss_pulse) begin
                cnt++;
                if (first == 0) first = c;
            end
        end
        n_run++;
        if (first != 11 || cnt != 1) begin
            n_fail++; $display("FAIL miss_timing: got cycle %0d count %0d expected 11/1", first, cnt);
        end
        n_run++;
        if (combo !== 8'd0 || miss_count !== 16'd1) begin
            n_fail++; $display("FAIL miss_counts: got combo %0d miss %0d expected 0/1", combo, miss_count);
        end
        n_run++;
        if (score !== 16'd10 || max_combo !== 8'd1) begin
            n_fail++; $display("FAIL miss_score: got %0d/%0d expected 10/1", score, max_combo);
        end
    endtask

    task automatic test_multi();
        int nh, nm;
        do_clear();
        n_run++;
        if (score !== 16'd0 || miss_count !== 16'd0 || max_combo !== 8'd0) begin
            n_fail++; $display("FAIL clear_counters: got %0d/%0d/%0d expected 0/0/0", score, miss_count, max_combo);
        end
        lanes = 7'b0100110;
        tick(4);
        key = 7'b0100110;
        watch(8, nh, nm);
        n_run++;
        if (nh != 1 || nm != 0) begin
            n_fail++; $display("FAIL multi_pulse: got %0d hits %0d misses expected 1/0", nh, nm);
        end
        n_run++;
        if (score !== 16'd30 || combo !== 8'd3 || max_combo !== 8'd3) begin
            n_fail++; $display("FAIL multi_score: got %0d/%0d/%0d expected 30/3/3", score, combo, max_combo);
        end
        key = '0;
        lanes = '0;
        tick(4);
    endtask

    task automatic test_wrong_shift();
        int nh, nm;
        int exp_score;
`ifdef JUDGE_WRONG_PENALTY_EN
        exp_score = 25;
`else
        exp_score = 30;
`endif
        wrong_seen = 0;
        bshift = 2'b10;
        user_shift = 2'b01;
        lanes[4] = 1'b1;
        tick(4);
        key[4] = 1'b1;
        watch(6, nh, nm);
        n_run++;
        if (nh != 0) begin
            n_fail++; $display("FAIL shift_nohit: got %0d hits expected 0", nh);
        end
        key = '0;
        lanes = '0;
        watch(14, nh, nm);
        n_run++;
        if (nm != 1) begin
            n_fail++; $display("FAIL shift_miss: got %0d misses expected 1", nm);
        end
        n_run++;
        if (score !== 16'(exp_score) || combo !== 8'd0 || miss_count !== 16'd1) begin
            n_fail++; $display("FAIL shift_counts: got %0d/%0d/%0d expected %0d/0/1", score, combo, miss_count, exp_score);
        end
`ifdef JUDGE_WRONG_PENALTY_EN
        n_run++;
        if (wrong_seen != 1) begin
            n_fail++; $display("FAIL wrong_pulse: got %0d expected 1", wrong_seen);
        end
`endif
        bshift = 2'b00;
        user_shift = 2'b00;
        tick(4);
    endtask

    task automatic test_enable();
        int nh, nm;
        int exp1, exp2;
`ifdef JUDGE_WRONG_PENALTY_EN
        exp1 = 25; exp2 = 20;
`else
        exp1 = 30; exp2 = 30;
`endif
        enable = 1'b0;
        lanes[6] = 1'b1;
        tick(4);
        key[6] = 1'b1;
        watch(8, nh, nm);
        n_run++;
        if (nh != 0 || score !== 16'(exp1)) begin
            n_fail++; $display("FAIL disabled_hold: got %0d hits score %0d expected 0/%0d", nh, score, exp1);
        end
        key = '0;
        enable = 1'b1;
        tick(3);
        key[6] = 1'b1;
        watch(8, nh, nm);
        n_run++;
        if (nh != 0) begin
            n_fail++; $display("FAIL partial_note_hit: got %0d hits expected 0", nh);
        end
        key = '0;
        lanes = '0;
        watch(14, nh, nm);
        n_run++;
        if (nm != 0 || score !== 16'(exp2)) begin
            n_fail++; $display("FAIL partial_note_miss: got %0d misses score %0d expected 0/%0d", nm, score, exp2);
        end
    endtask

    task automatic test_reset_mid();
        int nh, nm;
        lanes = 7'b0100001;
        tick(4);
        lanes = 7'b0100000;
        tick(4);
        #2 rst_n = 1'b0;
        #1;
        n_run++;
        if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL async_reset: got %0d/%0d/%0d/%0d expected 0/0/0/0", score, combo, max_combo, miss_count);
        end
        tick(2);
        rst_n = 1'b1;
        watch(20, nh, nm);
        n_run++;
        if (nh != 0 || nm != 0) begin
            n_fail++; $display("FAIL reset_grace: got %0d hits %0d misses expected 0/0", nh, nm);
        end
        key[5] = 1'b1;
        watch(8, nh, nm);
        n_run++;
        if (nh != 0) begin
            n_fail++; $display("FAIL reset_held_hit: got %0d hits expected 0", nh);
        end
        key = '0;
        lanes = '0;
        watch(14, nh, nm);
        n_run++;
        if (nm != 0 || miss_count !== 16'd0 || score !== 16'd0) begin
            n_fail++; $display("FAIL reset_held_miss: got %0d misses count %0d score %0d expected 0/0/0", nm, miss_count, score);
        end
    endtask

    task automatic test_clear_held();
        int nh, nm;
        lanes[1] = 1'b1;
        tick(4);
        key[1] = 1'b1;
        tick(6);
        key = '0;
        n_run++;
        if (score !== 16'd10) begin
            n_fail++; $display("FAIL pre_clear_score: got %0d expected 10", score);
        end
        lanes = 7'b0000110;
        tick(4);
        do_clear();
        n_run++;
        if (score !== 16'd0 || combo !== 8'd0 || max_combo !== 8'd0) begin
            n_fail++; $display("FAIL clear_held: got %0d/%0d/%0d expected 0/0/0", score, combo, max_combo);
        end
        key[2] = 1'b1;
        watch(8, nh, nm);
        n_run++;
        if (nh != 0) begin
            n_fail++; $display("FAIL clear_held_hit: got %0d hits expected 0", nh);
        end
        key = '0;
        lanes = '0;
        watch(14, nh, nm);
        n_run++;
        if (nm != 0 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL clear_held_miss: got %0d misses count %0d expected 0/0", nm, miss_count);
        end
    endtask

    task automatic chord();
        lanes = 7'h7f;
        tick(3);
        key = 7'h7f;
        tick(6);
        key = '0;
        lanes = '0;
        tick(4);
    endtask

    task automatic test_saturation();
        do_clear();
        for (int i = 0; i < 936; i++) chord();
        n_run++;
        if (score !== 16'd65520) begin
            n_fail++; $display("FAIL preload_score: got %0d expected 65520", score);
        end
        n_run++;
        if (combo !== 8'd255 || max_combo !== 8'd255) begin
            n_fail++; $display("FAIL combo_sat: got %0d/%0d expected 255/255", combo, max_combo);
        end
        chord();
        n_run++;
        if (score !== 16'd65535) begin
            n_fail++; $display("FAIL score_sat: got %0d expected 65535", score);
        end
        n_run++;
        if (combo !== 8'd255 || miss_count !== 16'd0) begin
            n_fail++; $display("FAIL combo_hold: got %0d miss %0d expected 255/0", combo, miss_count);
        end
    endtask

    initial begin
        rst_n = 1'b0;
        lanes = '0;
        bshift = 2'b00;
        key = '0;
        user_shift = 2'b00;
        enable = 1'b1;
        clear = 1'b0;
        test_reset();
        test_hit();
        test_miss();
        test_multi();
        test_wrong_shift();
        test_enable();
        test_reset_mid();
        test_clear_held();
        test_saturation();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
